// File: rtl/eliminate.sv
// eliminate: 8x8 match-3 detector; marks horizontal/vertical runs of equal nonzero
// pieces in a captured board snapshot and clears them all at once.
module eliminate (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] board_in,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [63:0]  clear_mask,
    output logic [6:0]   cleared_count,
    output logic [191:0] board_out
);
    typedef enum logic [2:0] {IDLE, ROW, COL, APPLY, DONE} state_t;
    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [191:0]  snap_q, snap_d;
    logic [63:0]   marks_q, marks_d, row_m, col_m;
    logic [2:0]    cells [64];
    logic [191:0]  cleared_b;
    logic          found_q;
    logic [63:0]   mask_q;
    logic [6:0]    count_q;
    logic [191:0]  bout_q;

    function automatic logic run3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return (a != 3'd0) && (a == b) && (b == c);
    endfunction

    for (genvar g = 0; g < 64; g++) begin : g_cell
        assign cells[g] = snap_q[3*g +: 3];
        assign cleared_b[3*g +: 3] = marks_q[g] ? 3'd0 : cells[g];
    end

    // Cell address is {row, col}, so {idx, k} walks a row and {k, idx} walks a column
    always_comb begin
        row_m = '0;
        col_m = '0;
        for (int k = 0; k < 6; k++) begin
            if (run3(cells[{idx_q, 3'(k)}], cells[{idx_q, 3'(k + 1)}], cells[{idx_q, 3'(k + 2)}])) begin
                row_m[{idx_q, 3'(k)}]     = 1'b1;
                row_m[{idx_q, 3'(k + 1)}] = 1'b1;
                row_m[{idx_q, 3'(k + 2)}] = 1'b1;
            end
            if (run3(cells[{3'(k), idx_q}], cells[{3'(k + 1), idx_q}], cells[{3'(k + 2), idx_q}])) begin
                col_m[{3'(k), idx_q}]     = 1'b1;
                col_m[{3'(k + 1), idx_q}] = 1'b1;
                col_m[{3'(k + 2), idx_q}] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        marks_d = marks_q;
        case (state_q)
            IDLE: if (start) begin
                snap_d  = board_in;
                marks_d = '0;
                idx_d   = 3'd0;
                state_d = ROW;
            end
            ROW: begin
                marks_d = marks_q | row_m;
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? COL : ROW;
            end
            COL: begin
                marks_d = marks_q | col_m;
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? APPLY : COL;
            end
            APPLY:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            snap_q  <= '0;
            marks_q <= '0;
            found_q <= 1'b0;
            mask_q  <= '0;
            count_q <= 7'd0;
            bout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            marks_q <= marks_d;
            if (state_q == APPLY) begin
                found_q <= |marks_q;
                mask_q  <= marks_q;
                count_q <= 7'($countones(marks_q));
                bout_q  <= cleared_b;
            end
        end
    end

    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign found         = found_q;
    assign clear_mask    = mask_q;
    assign cleared_count = count_q;
    assign board_out     = bout_q;
endmodule

// File: tb/tb_eliminate.sv
// tb_eliminate: directed and random passes through eliminate, checked against a
// run-length based reference model of match clearing.
module tb_eliminate;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [191:0] board_in = '0;
    logic         busy, done, found;
    logic [63:0]  clear_mask;
    logic [6:0]   cleared_count;
    logic [191:0] board_out;
    int checks = 0;
    int errors = 0;
    int seen;
    logic [191:0] cb, hb, lb, eb, rb, ob;

    eliminate dut (
        .clk(clk), .rst(rst), .start(start), .board_in(board_in),
        .busy(busy), .done(done), .found(found), .clear_mask(clear_mask),
        .cleared_count(cleared_count), .board_out(board_out)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] getc(input logic [191:0] b, input int r, input int c);
        return b[3*(8*r+c) +: 3];
    endfunction

    function automatic logic [191:0] setc(input logic [191:0] b, input int r, input int c, input int v);
        b[3*(8*r+c) +: 3] = 3'(v);
        return b;
    endfunction

    // Find maximal runs of one colour along each line; any nonzero run of 3+ is cleared
    function automatic logic [63:0] model_mask(input logic [191:0] b);
        logic [63:0] m;
        logic [2:0] v;
        int c, e;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            c = 0;
            while (c < 8) begin
                v = getc(b, r, c);
                e = c;
                while (e < 8 && getc(b, r, e) == v) e++;
                if (v != 0 && e - c >= 3)
                    for (int j = c; j < e; j++) m[6'(8*r+j)] = 1'b1;
                c = e;
            end
        end
        for (int col = 0; col < 8; col++) begin
            c = 0;
            while (c < 8) begin
                v = getc(b, c, col);
                e = c;
                while (e < 8 && getc(b, e, col) == v) e++;
                if (v != 0 && e - c >= 3)
                    for (int j = c; j < e; j++) m[6'(8*j+col)] = 1'b1;
                c = e;
            end
        end
        return m;
    endfunction

    function automatic logic [191:0] model_board(input logic [191:0] b, input logic [63:0] m);
        for (int g = 0; g < 64; g++) if (m[g]) b[3*g +: 3] = 3'd0;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, o, e);
        end
    endtask

    task automatic expect_results(input logic [191:0] brd);
        logic [63:0] m;
        m = model_mask(brd);
        chk("found", found, m != 0);
        chk("mask", clear_mask, m);
        chk("count", cleared_count, 7'($countones(m)));
        chk("board", board_out, model_board(brd, m));
    endtask

    // Called at a negedge; start is sampled on the next posedge (E0)
    task automatic pass(input logic [191:0] brd, input int dup_at, input logic [191:0] other);
        int dcnt, dat;
        dcnt = 0;
        dat = -1;
        board_in = brd;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        board_in = ~brd;
        chk("busy_e0", busy, 1);
        for (int n = 1; n <= 18; n++) begin
            if (n == dup_at) begin
                start = 1'b1;
                board_in = other;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dcnt++;
                dat = n;
            end
        end
        chk("busy_e18", busy, 0);
        chk("done_at", dat, 17);
        chk("done_cnt", dcnt, 1);
        expect_results(brd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_mask", clear_mask, 0);
        chk("rst_count", cleared_count, 0);
        chk("rst_board", board_out, 0);

        cb = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cb = setc(cb, r, c, ((r + c) % 2) ? 2 : 1);
        pass(cb, 0, '0);
        chk("cb_found", found, 0);
        chk("cb_count", cleared_count, 0);
        chk("cb_board", board_out, cb);

        hb = setc(setc(setc(setc(cb, 0, 0, 3), 0, 1, 3), 0, 2, 3), 0, 3, 4);
        pass(hb, 0, '0);
        chk("h_mask", clear_mask, 64'h7);
        chk("h_count", cleared_count, 3);
        chk("h_low", board_out[8:0], 0);
        chk("h_cell03", board_out[11:9], 4);

        lb = cb;
        for (int c = 2; c <= 6; c++) lb = setc(lb, 5, c, 5);
        for (int r = 3; r <= 5; r++) lb = setc(lb, r, 2, 5);
        pass(lb, 0, '0);
        chk("l_count", cleared_count, 7);
        chk("l_mask", clear_mask, 64'h0000_7C04_0400_0000);

        eb = cb;
        for (int i = 0; i < 8; i++) eb = setc(setc(eb, 7, i, 0), i, 0, 0);
        pass(eb, 0, '0);
        chk("e_found", found, 0);
        chk("e_count", cleared_count, 0);

        pass(hb, 5, lb);
        chk("dup_mask", clear_mask, 64'h7);

        board_in = lb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("ab_seen", seen, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_found", found, 0);
        chk("ab_mask", clear_mask, 0);
        chk("ab_count", cleared_count, 0);
        chk("ab_board", board_out, 0);
        @(posedge clk);
        @(negedge clk);
        pass(lb, 0, '0);

        for (int t = 0; t < 14; t++) begin
            rb = '0;
            ob = '0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    rb = setc(rb, r, c, (t % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 7)));
                    ob = setc(ob, r, c, int'($urandom_range(0, 2)));
                end
            pass(rb, int'($urandom_range(0, 17)), ob);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
